grid_valve_sequencer: RTL and testbench
=======================================

// Module: grid_valve_sequencer
// PURPOSE
//  Timed pneumatic controller for a parametrised cell-trap grid: input MUX, NUM_STAGES trap stages, flush tree.
//  Accepts one command (input select, last stage, fill/hold times) and drives the valve air lines through
//  SELECT -> FILL -> HOLD -> FLUSH. Replaces hand-toggled c/d/e control pins on the chip tester board.
// PARAMETERS
//  NUM_INPUTS  8    fluid inputs on the MUX; power of two, >=2; SEL_W = $clog2(NUM_INPUTS)
//  NUM_STAGES  8    GRID stages in the chain; 1..32
//  TIMER_W     16   width of all phase timers (cycles)
//  SETTLE_CYC  64   fixed MUX settle time after select, before fill valves open
// PORTS
//  clk        in   1            system clock
//  rst_n      in   1            asynchronous active-low reset
//  cmd_valid  in   1            command offered
//  cmd_ready  out  1            1 only in IDLE
//  cmd_sel    in   SEL_W        MUX input index
//  cmd_stage  in   $clog2(NUM_STAGES+1)  last stage to fill (0-based)
//  cmd_fill   in   TIMER_W      FILL duration, cycles
//  cmd_hold   in   TIMER_W      HOLD duration; FLUSH uses the same value
//  mux_air    out  2*SEL_W      pair per MUX level: [2k]=bit k is 0, [2k+1]=bit k is 1; 1 = valve open
//  d_air      out  NUM_STAGES   stage trap-path valves; 1 = open
//  e_air      out  NUM_STAGES   stage bypass/flush valves; 1 = open
//  busy       out  1            state != IDLE
//  done       out  1            one-cycle pulse on FLUSH -> IDLE
//  err        out  1            one-cycle pulse when a command is rejected
// BEHAVIOUR
//  Reset: IDLE; every output 0 except cmd_ready=1; all valves closed. Reset mid-sequence closes all valves at once.
//  Handshake: accepted on clk edge with cmd_valid & cmd_ready; fields captured into registers on that edge.
//  Rejection: cmd_stage >= NUM_STAGES -> no state change, err=1 next cycle, cmd_ready stays 1.
//  IDLE   -> SELECT on accept. mux_air = decoded sel (exactly one bit per pair), held through FILL and HOLD.
//  SELECT : timer = SETTLE_CYC; d/e all 0. Exits when timer expires.
//  FILL   : d_air[i]=1 for i<=stage, else 0; e_air=0. Duration max(cmd_fill,1) cycles.
//  HOLD   : d_air=0, e_air=0, mux_air unchanged. Duration max(cmd_hold,1) cycles.
//  FLUSH  : mux_air=0; e_air[i]=1 for i<=stage; d_air=0. Duration max(cmd_hold,1); then IDLE with done=1.
//  Phase length N means outputs hold that phase for exactly N clk cycles; next phase starts cycle N+1.
//  Latency: accept edge to first FILL cycle = SETTLE_CYC+1 cycles. Outputs registered, no combinational paths in->out.
//  Never d_air[i] and e_air[i] both 1; never both bits of a mux_air pair 1 (assertions in RTL).
//  cmd_valid during busy ignored (not queued). Timer is a down-counter; zero loads as 1, no wrap.
// CONFIGURATION
//  GRID_SEQ_ABORT_EN defined: adds input `abort` (1 bit). abort=1 in SELECT/FILL/HOLD -> next cycle FLUSH with full
//   flush time, mux_air=0; done still pulses at end; abort in IDLE/FLUSH ignored.
//  Not defined: no abort port; sequence always runs to completion.
// STRUCTURE
//  grid_seq_pkg: state enum (IDLE,SELECT,FILL,HOLD,FLUSH), function mux_decode(sel)->2*SEL_W pairs,
//   function stage_mask(stage)->NUM_STAGES thermometer.
//  Sub-module grid_seq_timer (TIMER_W down-counter: load, value, expire pulse); one instance, reloaded per phase.
// TESTING
//  sel=5,stage=3,fill=10,hold=4 -> mux_air=6'b100110 from cycle 1; d_air=8'h0F 10 cycles; hold 4; e_air=8'h0F 4; done.
//  cmd_stage=8 (NUM_STAGES=8) -> err pulse 1 cycle, busy stays 0, all valves 0.
//  fill=0,hold=0 -> FILL, HOLD, FLUSH each exactly 1 cycle; done at accept+SETTLE_CYC+4.
//  rst_n low mid-FILL -> d_air/e_air/mux_air 0 without clk edge; cmd_ready=1 after release.
//  cmd_valid held high through a run -> second command accepted only on the cycle after done.
//  GRID_SEQ_ABORT_EN, abort in HOLD cycle 2, hold=6 -> FLUSH next cycle lasting 6 cycles, done pulses.

Source files
------------

// File: rtl/grid_valve_sequencer_pkg.sv
// Shared definitions for the grid valve sequencer: phase encodings and the
// combinational helpers that turn a command into valve patterns.
package grid_seq_pkg;

    // Widest configurations the helpers cover; callers cast down to their size.
    localparam int MAX_SEL_W  = 8;
    localparam int MAX_STAGES = 32;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd1;
    localparam logic [2:0] ST_FILL   = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_FLUSH  = 3'd4;

    // One open valve per MUX level: [2k] opens when sel bit k is 0, [2k+1] when it is 1.
    function automatic logic [2*MAX_SEL_W-1:0] mux_decode(input logic [MAX_SEL_W-1:0] sel);
        logic [2*MAX_SEL_W-1:0] pairs;
        pairs = '0;
        for (int k = 0; k < MAX_SEL_W; k++) begin
            if (sel[k]) pairs[2*k+1] = 1'b1;
            else        pairs[2*k]   = 1'b1;
        end
        return pairs;
    endfunction

    // Thermometer mask: stages 0..stage inclusive are set.
    function automatic logic [MAX_STAGES-1:0] stage_mask(input logic [5:0] stage);
        logic [MAX_STAGES-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_STAGES; i++) begin
            mask[i] = (i <= int'(stage));
        end
        return mask;
    endfunction

endpackage

// File: rtl/grid_valve_sequencer_if.sv
// Command channel of the grid valve sequencer: valid/ready handshake plus
// the command fields (input select, last stage, fill and hold times).
interface grid_valve_sequencer_if #(
    parameter int SEL_W   = 3,
    parameter int STAGE_W = 4,
    parameter int TIMER_W = 16
) ();
    logic               cmd_valid;
    logic               cmd_ready;
    logic [SEL_W-1:0]   cmd_sel;
    logic [STAGE_W-1:0] cmd_stage;
    logic [TIMER_W-1:0] cmd_fill;
    logic [TIMER_W-1:0] cmd_hold;

    modport master (
        output cmd_valid, cmd_sel, cmd_stage, cmd_fill, cmd_hold,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_sel, cmd_stage, cmd_fill, cmd_hold,
        output cmd_ready
    );
endinterface

// File: rtl/grid_valve_sequencer_timer.sv
// Phase timer: loadable down-counter that stops at zero. expire is high
// during the last cycle of a phase (count == 1), so a phase loaded with N
// lasts exactly N cycles.
module grid_seq_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic [TIMER_W-1:0] value,
    output logic               expire
);

    // Load wins over counting; the count parks at zero instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (value != '0) begin
            value <= value - 1'b1;
        end
    end

    assign expire = (value == TIMER_W'(1));

endmodule

// File: rtl/grid_valve_sequencer.sv
// Timed pneumatic controller for the cell-trap grid: one command walks the
// valves through SELECT -> FILL -> HOLD -> FLUSH and returns to IDLE.
// All valve and status outputs are registered from the next phase.
// Optional feature: define GRID_SEQ_ABORT_EN to add the `abort` input, which
// cuts SELECT/FILL/HOLD short and jumps straight to a full-length FLUSH.
module grid_valve_sequencer
    import grid_seq_pkg::*;
#(
    parameter int NUM_INPUTS = 8,
    parameter int NUM_STAGES = 8,
    parameter int TIMER_W    = 16,
    parameter int SETTLE_CYC = 64,
    localparam int SEL_W     = $clog2(NUM_INPUTS),
    localparam int STAGE_W   = $clog2(NUM_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    grid_valve_sequencer_if.slave cmd,
`ifdef GRID_SEQ_ABORT_EN
    input  logic                  abort,
`endif
    output logic [2*SEL_W-1:0]    mux_air,
    output logic [NUM_STAGES-1:0] d_air,
    output logic [NUM_STAGES-1:0] e_air,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    state_t             state_q;
    state_t             state_n;
    logic               ready_q;
    logic               accept;
    logic               reject;
    logic               abort_req;

    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   sel_n;
    logic [STAGE_W-1:0] stage_q;
    logic [TIMER_W-1:0] fill_q;
    logic [TIMER_W-1:0] hold_q;
    logic [TIMER_W-1:0] fill_len;
    logic [TIMER_W-1:0] hold_len;

    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic [TIMER_W-1:0] tmr_value;
    logic               tmr_expire;

`ifdef GRID_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign cmd.cmd_ready = ready_q;

    // Out-of-range stages are refused at the handshake and never reach the FSM.
    assign accept = cmd.cmd_valid & ready_q & (cmd.cmd_stage <  STAGE_W'(NUM_STAGES));
    assign reject = cmd.cmd_valid & ready_q & (cmd.cmd_stage >= STAGE_W'(NUM_STAGES));

    // A zero duration still gives a one-cycle phase.
    assign fill_len = (fill_q == '0) ? TIMER_W'(1) : fill_q;
    assign hold_len = (hold_q == '0) ? TIMER_W'(1) : hold_q;

    // The accept edge already drives the MUX, so bypass the capture register there.
    assign sel_n = accept ? cmd.cmd_sel : sel_q;

    grid_seq_timer #(
        .TIMER_W  (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .value    (tmr_value),
        .expire   (tmr_expire)
    );

    // Capture the command fields on the accepting edge; they are data, not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            sel_q   <= cmd.cmd_sel;
            stage_q <= cmd.cmd_stage;
            fill_q  <= cmd.cmd_fill;
            hold_q  <= cmd.cmd_hold;
        end
    end

    // Phase sequencing; every transition reloads the timer for the phase being entered.
    always_comb begin
        state_n  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_n  = ST_SELECT;
                    tmr_load = 1'b1;
                    tmr_val  = TIMER_W'(SETTLE_CYC);
                end
            end
            ST_SELECT: begin
                if (abort_req) begin
                    state_n  = ST_FLUSH;
                    tmr_load = 1'b1;
                    tmr_val  = hold_len;
                end else if (tmr_expire) begin
                    state_n  = ST_FILL;
                    tmr_load = 1'b1;
                    tmr_val  = fill_len;
                end
            end
            ST_FILL: begin
                if (abort_req) begin
                    state_n  = ST_FLUSH;
                    tmr_load = 1'b1;
                    tmr_val  = hold_len;
                end else if (tmr_expire) begin
                    state_n  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = hold_len;
                end
            end
            ST_HOLD: begin
                if (abort_req || tmr_expire) begin
                    state_n  = ST_FLUSH;
                    tmr_load = 1'b1;
                    tmr_val  = hold_len;
                end
            end
            ST_FLUSH: begin
                if (tmr_expire) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, decoded from the phase being entered; reset closes every valve at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            mux_air <= '0;
            d_air   <= '0;
            e_air   <= '0;
        end else begin
            state_q <= state_n;
            ready_q <= (state_n == ST_IDLE);
            busy    <= (state_n != ST_IDLE);
            done    <= (state_q == ST_FLUSH) && (state_n == ST_IDLE);
            err     <= reject;
            mux_air <= (state_n == ST_SELECT || state_n == ST_FILL || state_n == ST_HOLD)
                       ? (2*SEL_W)'(mux_decode(MAX_SEL_W'(sel_n))) : '0;
            d_air   <= (state_n == ST_FILL)  ? NUM_STAGES'(stage_mask(6'(stage_q))) : '0;
            e_air   <= (state_n == ST_FLUSH) ? NUM_STAGES'(stage_mask(6'(stage_q))) : '0;
        end
    end

    logic [SEL_W-1:0] pair_clash;

    // Flag any MUX level with both of its valves open.
    always_comb begin
        pair_clash = '0;
        for (int k = 0; k < SEL_W; k++) begin
            pair_clash[k] = mux_air[2*k] & mux_air[2*k+1];
        end
    end

    a_no_trap_bypass_clash: assert property (@(posedge clk) disable iff (!rst_n)
        (d_air & e_air) == '0);
    a_no_mux_pair_clash: assert property (@(posedge clk) disable iff (!rst_n)
        pair_clash == '0);
    a_timer_idle_parked: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_IDLE) |-> (tmr_value == '0));

endmodule

// File: tb/tb_grid_valve_sequencer.sv
// Scoreboard bench for grid_valve_sequencer (NUM_INPUTS=8, NUM_STAGES=8,
// SETTLE_CYC=64). Each command pushes its expected per-cycle output trace;
// the drain loop pops one entry per clock and compares the whole output set.
module tb_grid_valve_sequencer;

    localparam int SETTLE = 64;

    logic clk;
    logic rst_n;
    logic [5:0] mux_air;
    logic [7:0] d_air;
    logic [7:0] e_air;
    logic busy, done, err;
`ifdef GRID_SEQ_ABORT_EN
    logic abort_in;
`endif

    int n_checks = 0;
    int n_errors = 0;
    string test_name;

    // {ready, busy, done, err, mux[5:0], d[7:0], e[7:0]}
    logic [25:0] exp_q[$];

    grid_valve_sequencer_if #(.SEL_W(3), .STAGE_W(4), .TIMER_W(16)) cmd_if ();

    grid_valve_sequencer #(
        .NUM_INPUTS (8),
        .NUM_STAGES (8),
        .TIMER_W    (16),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cmd     (cmd_if),
`ifdef GRID_SEQ_ABORT_EN
        .abort   (abort_in),
`endif
        .mux_air (mux_air),
        .d_air   (d_air),
        .e_air   (e_air),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [25:0] mk(input logic rdy, input logic bsy, input logic dn,
                                       input logic er, input logic [5:0] mx,
                                       input logic [7:0] d, input logic [7:0] e);
        return {rdy, bsy, dn, er, mx, d, e};
    endfunction

    function automatic logic [25:0] observed();
        return {cmd_if.cmd_ready, busy, done, err, mux_air, d_air, e_air};
    endfunction

    // Expected trace from the cycle after the accept edge through the done cycle.
    task automatic push_run(input logic [5:0] mx, input logic [7:0] mask,
                            input int fill, input int hold, input int hold_cut);
        int f  = (fill == 0) ? 1 : fill;
        int h  = (hold == 0) ? 1 : hold;
        int hc = (hold_cut > 0) ? hold_cut : h;
        repeat (SETTLE) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, mx, 8'h00, 8'h00));
        repeat (f)      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, mx, mask, 8'h00));
        repeat (hc)     exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, mx, 8'h00, 8'h00));
        repeat (h)      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 6'b0, 8'h00, mask));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 6'b0, 8'h00, 8'h00));
    endtask

    task automatic offer(input logic [2:0] sel, input logic [3:0] stage,
                         input logic [15:0] fill, input logic [15:0] hold);
        cmd_if.cmd_sel   = sel;
        cmd_if.cmd_stage = stage;
        cmd_if.cmd_fill  = fill;
        cmd_if.cmd_hold  = hold;
        cmd_if.cmd_valid = 1'b1;
    endtask

    // One clock per queue entry; inputs change and outputs are sampled 1 ns after the edge.
    task automatic drain(input int drop_idx, input int abort_idx, input int stop_idx);
        int n = 0;
        logic [25:0] e;
        while (exp_q.size() > 0 && n < stop_idx) begin
            @(posedge clk);
            #1;
            if (n >= drop_idx) cmd_if.cmd_valid = 1'b0;
`ifdef GRID_SEQ_ABORT_EN
            abort_in = 1'b0;
`endif
            e = exp_q.pop_front();
            check_val($sformatf("%s_c%0d", test_name, n), 32'(observed()), 32'(e));
`ifdef GRID_SEQ_ABORT_EN
            if (n == abort_idx) abort_in = 1'b1;
`else
            if (n == abort_idx) cmd_if.cmd_valid = 1'b0;
`endif
            n++;
        end
    endtask

    initial begin
        rst_n            = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_sel   = '0;
        cmd_if.cmd_stage = '0;
        cmd_if.cmd_fill  = '0;
        cmd_if.cmd_hold  = '0;
`ifdef GRID_SEQ_ABORT_EN
        abort_in         = 1'b0;
`endif
        #3 rst_n = 1'b0;
        #1;
        check_val("reset_async", 32'(observed()), 32'(mk(1'b1, 1'b0, 1'b0, 1'b0, 6'b0, 8'h00, 8'h00)));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("reset_idle", 32'(observed()), 32'(mk(1'b1, 1'b0, 1'b0, 1'b0, 6'b0, 8'h00, 8'h00)));

        // Reference run: sel=5 -> 6'b100110, stages 0..3 -> 8'h0F.
        test_name = "ref";
        offer(3'd5, 4'd3, 16'd10, 16'd4);
        push_run(6'b100110, 8'h0F, 10, 4, 0);
        drain(0, -1, 1 << 20);

        // Stage index equal to NUM_STAGES is refused: err pulse only.
        test_name = "reject";
        offer(3'd2, 4'd8, 16'd5, 16'd5);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 6'b0, 8'h00, 8'h00));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 6'b0, 8'h00, 8'h00));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 6'b0, 8'h00, 8'h00));
        drain(0, -1, 1 << 20);

        // Zero times: each timed phase lasts one cycle; done at accept+SETTLE+4.
        test_name = "zero";
        offer(3'd0, 4'd0, 16'd0, 16'd0);
        push_run(6'b010101, 8'h01, 0, 0, 0);
        drain(0, -1, 1 << 20);

        // All stages, top input.
        test_name = "full";
        offer(3'd7, 4'd7, 16'd3, 16'd2);
        push_run(6'b101010, 8'hFF, 3, 2, 0);
        drain(0, -1, 1 << 20);

        // Reset asserted in the middle of FILL.
        test_name = "midrst";
        offer(3'd2, 4'd1, 16'd20, 16'd3);
        push_run(6'b011001, 8'h03, 20, 3, 0);
        drain(0, -1, SETTLE + 6);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_async", 32'(observed()), 32'(mk(1'b1, 1'b0, 1'b0, 1'b0, 6'b0, 8'h00, 8'h00)));
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("midrst_release", 32'(observed()), 32'(mk(1'b1, 1'b0, 1'b0, 1'b0, 6'b0, 8'h00, 8'h00)));

        // cmd_valid held through a run: the second accept lands on the done cycle's edge.
        test_name = "held";
        offer(3'd1, 4'd2, 16'd2, 16'd1);
        push_run(6'b010110, 8'h07, 2, 1, 0);
        push_run(6'b010110, 8'h07, 2, 1, 0);
        drain(SETTLE + 2 + 1 + 1 + 1, -1, 1 << 20);

`ifdef GRID_SEQ_ABORT_EN
        // Abort during HOLD cycle 2 -> full-length FLUSH next cycle.
        test_name = "abort";
        offer(3'd4, 4'd5, 16'd3, 16'd6);
        push_run(6'b100101, 8'h3F, 3, 6, 2);
        drain(0, SETTLE + 3 + 1, 1 << 20);
`endif

        @(posedge clk);
        #1;
        check_val("final_idle", 32'(observed()), 32'(mk(1'b1, 1'b0, 1'b0, 1'b0, 6'b0, 8'h00, 8'h00)));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
